// File: rtl/downsample_pkg.sv
// downsample_pkg: shared constants, FSM states and pixel descriptor type for the downsample scheduler
package downsample_pkg;
  localparam int MAX_DIM = 64;
  localparam int IDX_W = $clog2(MAX_DIM) + 1;
  localparam int STRIDE_W = 16;
  localparam int ACC_W = IDX_W + 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} ds_state_e;
  typedef struct packed {
    logic [IDX_W-1:0] floor_h;
    logic [IDX_W-1:0] ceil_h;
    logic [IDX_W-1:0] floor_w;
    logic [IDX_W-1:0] ceil_w;
    logic [7:0] frac_y;
    logic [7:0] frac_x;
    logic [IDX_W-1:0] oi;
    logic [IDX_W-1:0] oj;
    logic last;
  } pix_desc_t;
endpackage

// File: rtl/stride_walker.sv
// stride_walker: one-axis Q8.8 stride accumulator producing next floor, clamped ceil and fraction
module stride_walker
  import downsample_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [IDX_W-1:0]    hin,
  output logic [IDX_W-1:0]    floor_d,
  output logic [IDX_W-1:0]    ceil_d,
  output logic [7:0]          frac_d
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] hmax;
  always_comb begin
    acc_d = clr ? '0 : inc ? ACC_W'(acc_q + stride) : acc_q;
    hmax = hin - IDX_W'(1);
    floor_d = acc_d[ACC_W-1:8];
    ceil_d = floor_d >= hmax ? hmax : floor_d + IDX_W'(1);
    frac_d = acc_d[7:0];
  end
  always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
endmodule

// File: rtl/downsample_scheduler.sv
// downsample_scheduler: raster-walks output pixels of one downsampling pass, emitting neighbour indices and fractions on a valid/ready stream
module downsample_scheduler
  import downsample_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [STRIDE_W-1:0] cfg_stride_q8_8,
  input  logic [IDX_W-1:0]    cfg_hin,
  input  logic [IDX_W-1:0]    cfg_hout,
  output logic                busy,
  output logic                done,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [IDX_W-1:0]    pix_floor_h,
  output logic [IDX_W-1:0]    pix_ceil_h,
  output logic [IDX_W-1:0]    pix_floor_w,
  output logic [IDX_W-1:0]    pix_ceil_w,
  output logic [7:0]          pix_frac_y,
  output logic [7:0]          pix_frac_x,
  output logic [IDX_W-1:0]    pix_oi,
  output logic [IDX_W-1:0]    pix_oj,
  output logic                pix_last
);
  ds_state_e state_q, state_d;
  pix_desc_t desc_q, desc_d;
  logic valid_q, valid_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic [IDX_W-1:0] hin_q, hin_d, hout_q, hout_d, hmax, oi_n, oj_n;
  logic accept, load, hs, adv, wrap, row_inc, col_inc, col_clr;
  logic [IDX_W-1:0] fh, ch, fw, cw;
  logic [7:0] fy, fx;
  stride_walker u_row (.clk, .rst, .clr(load), .inc(row_inc), .stride(stride_d), .hin(hin_d),
                       .floor_d(fh), .ceil_d(ch), .frac_d(fy));
  stride_walker u_col (.clk, .rst, .clr(col_clr), .inc(col_inc), .stride(stride_d), .hin(hin_d),
                       .floor_d(fw), .ceil_d(cw), .frac_d(fx));
  always_comb begin
    accept = state_q == IDLE && start;
    load = accept && cfg_hout != '0;
    hs = valid_q && pix_ready;
    adv = hs && !desc_q.last;
    hmax = hout_q - IDX_W'(1);
    wrap = desc_q.oj == hmax;
    row_inc = adv && wrap;
    col_inc = adv && !wrap;
    col_clr = load || row_inc;
    stride_d = accept ? cfg_stride_q8_8 : stride_q;
    hin_d = accept ? cfg_hin : hin_q;
    hout_d = accept ? cfg_hout : hout_q;
    oi_n = load ? '0 : row_inc ? desc_q.oi + IDX_W'(1) : desc_q.oi;
    oj_n = col_clr ? '0 : desc_q.oj + IDX_W'(1);
    desc_d = desc_q;
    if (load || adv)
      desc_d = '{floor_h: fh, ceil_h: ch, floor_w: fw, ceil_w: cw, frac_y: fy, frac_x: fx,
                 oi: oi_n, oj: oj_n,
                 last: oi_n == hout_d - IDX_W'(1) && oj_n == hout_d - IDX_W'(1)};
    state_d = state_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        state_d = accept ? (load ? RUN : DONE) : IDLE;
        valid_d = load;
      end
      RUN: begin
        state_d = hs && desc_q.last ? DONE : RUN;
        valid_d = !(hs && desc_q.last);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      desc_q <= '0;
      stride_q <= '0;
      hin_q <= '0;
      hout_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      desc_q <= desc_d;
      stride_q <= stride_d;
      hin_q <= hin_d;
      hout_q <= hout_d;
    end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign pix_valid = valid_q;
  assign pix_floor_h = desc_q.floor_h;
  assign pix_ceil_h = desc_q.ceil_h;
  assign pix_floor_w = desc_q.floor_w;
  assign pix_ceil_w = desc_q.ceil_w;
  assign pix_frac_y = desc_q.frac_y;
  assign pix_frac_x = desc_q.frac_x;
  assign pix_oi = desc_q.oi;
  assign pix_oj = desc_q.oj;
  assign pix_last = desc_q.last;
endmodule

// File: tb/tb_downsample_scheduler.sv
// tb_downsample_scheduler: randomized self-checking bench against an arithmetic reference of the pixel walk
module tb_downsample_scheduler;
  logic clk = 0, rst = 1, start = 0, pix_ready = 0;
  logic [15:0] cfg_stride_q8_8 = 0;
  logic [6:0] cfg_hin = 0, cfg_hout = 0;
  logic busy, done, pix_valid, pix_last;
  logic [6:0] pix_floor_h, pix_ceil_h, pix_floor_w, pix_ceil_w, pix_oi, pix_oj;
  logic [7:0] pix_frac_y, pix_frac_x;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  downsample_scheduler dut (.clk(clk), .rst(rst), .start(start), .cfg_stride_q8_8(cfg_stride_q8_8),
    .cfg_hin(cfg_hin), .cfg_hout(cfg_hout), .busy(busy), .done(done), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_floor_h(pix_floor_h), .pix_ceil_h(pix_ceil_h),
    .pix_floor_w(pix_floor_w), .pix_ceil_w(pix_ceil_w), .pix_frac_y(pix_frac_y),
    .pix_frac_x(pix_frac_x), .pix_oi(pix_oi), .pix_oj(pix_oj), .pix_last(pix_last));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [63:0] cur_desc();
    return 64'({pix_floor_h, pix_ceil_h, pix_floor_w, pix_ceil_w, pix_frac_y, pix_frac_x,
                pix_oi, pix_oj, pix_last});
  endfunction
  function automatic logic [63:0] model(input int s, input int hi, input int ho, input int oi, input int oj);
    int ah = s * oi, aw = s * oj;
    int fh = ah / 256, fw = aw / 256;
    int ch = (fh + 1 > hi - 1) ? hi - 1 : fh + 1;
    int cw = (fw + 1 > hi - 1) ? hi - 1 : fw + 1;
    return 64'({7'(fh), 7'(ch), 7'(fw), 7'(cw), 8'(ah % 256), 8'(aw % 256), 7'(oi), 7'(oj),
                oi == ho - 1 && oj == ho - 1});
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_pass(input int s, input int hi, input int ho, input int pct, input int mid);
    int oi = 0, oj = 0, cyc = 0;
    logic [63:0] held = 0;
    bit stalled = 0;
    start = 1; cfg_stride_q8_8 = 16'(s); cfg_hin = 7'(hi); cfg_hout = 7'(ho);
    tick();
    start = 0;
    check("busy_after_start", 64'(busy), 1);
    if (ho == 0) begin
      check("empty_valid", 64'(pix_valid), 0);
      check("empty_done", 64'(done), 1);
      tick();
      check("empty_idle", 64'({busy, done, pix_valid}), 0);
      return;
    end
    while (oi < ho && cyc < 20000) begin
      start = (cyc == mid);
      if (cyc == mid) begin
        cfg_hout = 2; cfg_hin = 5; cfg_stride_q8_8 = 16'($urandom_range(600, 100));
      end
      pix_ready = $urandom_range(99) < pct;
      check("valid_held", 64'({pix_valid, done}), 64'b10);
      if (stalled) check("stall_stable", cur_desc(), held);
      if (pix_ready) begin
        check("desc", cur_desc(), model(s, hi, ho, oi, oj));
        if (s == 369 && hi == 27 && oi == 0 && oj == 1)
          check("desc_0_1", 64'({pix_floor_w, pix_frac_x}), 64'({7'd1, 8'h71}));
        if (s == 369 && hi == 27 && oi == 18 && oj == 18)
          check("desc_18_18", 64'({pix_floor_h, pix_ceil_h, pix_frac_y, pix_last}),
                64'({7'd25, 7'd26, 8'hF2, 1'b1}));
        if (s == 256 && hi == 4 && oi == 3)
          check("clamp_ceil_h", 64'({pix_floor_h, pix_ceil_h, pix_floor_w}), 64'({7'd3, 7'd3, 7'(oj)}));
        oj++;
        if (oj == ho) begin oj = 0; oi++; end
        stalled = 0;
      end else begin
        held = cur_desc();
        stalled = 1;
      end
      tick();
      cyc++;
    end
    start = 0;
    pix_ready = 0;
    if (cyc >= 20000) check("pass_timeout", 0, 1);
    check("done_pulse", 64'({done, busy, pix_valid}), 64'b110);
    tick();
    check("done_clear", 64'({done, busy}), 0);
    tick();
    check("no_second_done", 64'({done, busy}), 0);
  endtask
  initial begin
    int cyc;
    tick(); tick();
    check("reset_flags", 64'({busy, done, pix_valid, pix_last}), 0);
    check("reset_desc", cur_desc(), 0);
    rst = 0;
    tick();
    run_pass(369, 27, 19, 100, -1);
    run_pass(256, 4, 4, 100, -1);
    run_pass(369, 27, 19, 50, -1);
    run_pass(300, 20, 3, 60, 4);
    run_pass(500, 9, 0, 100, -1);
    for (int k = 0; k < 6; k++) begin
      int ho = $urandom_range(12, 1);
      int hi = $urandom_range(64, ho);
      int smax = ho > 1 ? ((hi - 1) * 256) / (ho - 1) : 2000;
      run_pass($urandom_range(smax > 65535 ? 65535 : smax, 0), hi, ho, $urandom_range(100, 30), -1);
    end
    start = 1; cfg_stride_q8_8 = 369; cfg_hin = 27; cfg_hout = 19;
    tick();
    start = 0;
    pix_ready = 1;
    cyc = 0;
    while (!(pix_valid && pix_oi == 5 && pix_oj == 3) && cyc < 500) begin tick(); cyc++; end
    if (cyc >= 500) check("reach_5_3_timeout", 0, 1);
    rst = 1;
    tick();
    rst = 0;
    pix_ready = 0;
    check("midpass_rst_flags", 64'({busy, done, pix_valid, pix_last}), 0);
    check("midpass_rst_desc", cur_desc(), 0);
    tick();
    check("rst_no_done", 64'({busy, done}), 0);
    run_pass(369, 27, 19, 70, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
